// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- shared definitions for the UART receiver.
//   DATA_W             : number of data bits per frame (8)
//   uart_state_t       : FSM state encoding type, with ST_* constants
//   calc_clks_per_bit  : integer floor of clk_freq / baud_rate
//   calc_cnt_width     : width of a counter that must hold clks-1
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_W = 8;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam uart_state_t ST_PARITY = 3'd3;
`endif
    localparam uart_state_t ST_STOP   = 3'd4;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // A counter counting 0..clks-1 never needs fewer than one bit.
    function automatic int calc_cnt_width(input int clks);
        if (clks > 1) begin
            return $clog2(clks);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- serial line and result signals of the UART receiver.
//   rx           : serial line into the receiver, idle high
//   rx_data      : last correctly received byte
//   rx_done_flag : one-cycle pulse, new byte valid on rx_data
//   frame_err    : one-cycle pulse, stop bit sampled low
//   parity_err   : one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
// master = line driver / result consumer, slave = the receiver.
// ---------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic              rx;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done_flag;
    logic              frame_err;
    logic              parity_err;

    modport master (
        output rx,
        input  rx_data,
        input  rx_done_flag,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  rx,
        output rx_data,
        output rx_done_flag,
        output frame_err,
        output parity_err
    );

endinterface

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync -- two-flop synchronizer for the asynchronous rx line.
//   clk : system clock
//   rst : synchronous active-high reset (flops reset to 1 = idle line)
//   d   : asynchronous input
//   q   : synchronized output
// ---------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    // Next-state of the two synchronizer stages.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchronizer stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- UART receiver, 8N1 (or 8E1 with UART_RX_PARITY_EN defined).
//   Parameters: CLK_FREQ (Hz), BAUD_RATE (baud)
//   clk  : system clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : uart_rx_if.slave (rx in; rx_data, rx_done_flag, frame_err,
//          parity_err out, all outputs registered)
// Macro UART_RX_PARITY_EN: adds an even-parity bit between data and stop.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    import uart_pkg::*;

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W        = calc_cnt_width(CLKS_PER_BIT);
    localparam int HALF_M1      = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_M1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic              rx_s;
    logic              fell_s;
    uart_state_t       state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [2:0]        bit_d, bit_q;
    logic [DATA_W-1:0] shift_d, shift_q;
    logic              prev_d, prev_q;
    logic [1:0]        settle_d, settle_q;
    logic [DATA_W-1:0] rx_data_d, rx_data_q;
    logic              done_d, done_q;
    logic              ferr_d, ferr_q;
`ifdef UART_RX_PARITY_EN
    logic              par_d, par_q;
    logic              perr_d, perr_q;
`endif

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    // A start edge needs the line to have been seen high (after the
    // synchronizer has flushed its reset value) and now to be low.
    assign fell_s = prev_q & ~rx_s;

    // Receiver FSM, bit timing and output pulse generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        settle_d  = {settle_q[0], 1'b1};
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        // Until two cycles after reset the synchronizer shows its reset
        // value, not the line, so it must not count as "seen high".
        if (settle_q[1]) begin
            prev_d = rx_s;
        end else begin
            prev_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (fell_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        rx_data_d = shift_q;
                        done_d    = 1'b1;
                    end else begin
                        ferr_d    = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    // Even parity: data bits plus parity bit XOR to 0.
                    perr_d = ^{shift_q, par_q};
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            prev_q    <= 1'b0;
            settle_q  <= 2'b00;
            rx_data_q <= 8'h00;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            prev_q    <= prev_d;
            settle_q  <= settle_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_done_flag = done_q;
    assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = perr_q;
`else
    assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at 1 MHz / 100 kBd
// (10 clocks per bit). Frames are built from the bit-level frame format;
// expected bytes and pulse counts come from a simple frame-level model.
// Honours UART_RX_PARITY_EN (even parity bit inserted before stop).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if u_if ();

    uart_rx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int checks = 0;
    int errors = 0;

    // Output monitor: counts pulses and captures received bytes.
    int         done_cnt       = 0;
    int         ferr_cnt       = 0;
    int         perr_cnt       = 0;
    int         perr_with_done = 0;
    int         coincide_cnt   = 0;
    int         wide_cnt       = 0;
    logic       prev_done      = 1'b0;
    logic       prev_ferr      = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (u_if.rx_done_flag === 1'b1) begin
            done_cnt <= done_cnt + 1;
            got_q.push_back(u_if.rx_data);
        end
        if (u_if.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (u_if.parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
        if (u_if.parity_err === 1'b1 && u_if.rx_done_flag === 1'b1) perr_with_done <= perr_with_done + 1;
        if (u_if.rx_done_flag === 1'b1 && u_if.frame_err === 1'b1) coincide_cnt <= coincide_cnt + 1;
        if ((u_if.rx_done_flag === 1'b1 && prev_done) || (u_if.frame_err === 1'b1 && prev_ferr))
            wide_cnt <= wide_cnt + 1;
        prev_done <= (u_if.rx_done_flag === 1'b1);
        prev_ferr <= (u_if.frame_err === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All drive tasks start and end just after a falling clock edge.
    task automatic drive_bit(input logic b);
        u_if.rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        u_if.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ ~par_ok);
`endif
        drive_bit(stop_b);
    endtask

    logic [7:0] exp_data;
    logic [7:0] exp_q[$];
    logic [7:0] rb;
    logic       rp;
    int         d0, f0, p0, pd0, exp_perr, nrand;

    initial begin
        u_if.rx  = 1'b1;
        exp_data = 8'h00;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", {24'd0, u_if.rx_data}, 32'h00);
        check("reset_done", {31'd0, u_if.rx_done_flag}, 32'd0);
        check("reset_frame_err", {31'd0, u_if.frame_err}, 32'd0);
        check("reset_parity_err", {31'd0, u_if.parity_err}, 32'd0);
        rst = 1'b0;
        idle(5);

        // Single frame 0x55
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, 1'b1); exp_data = 8'h55;
        idle(2 * CPB);
        check("b55_done_count", done_cnt - d0, 32'd1);
        check("b55_rx_data", {24'd0, u_if.rx_data}, {24'd0, exp_data});
        check("b55_frame_err", ferr_cnt - f0, 32'd0);
        got_q.delete();

        // Back-to-back frames 0xA3, 0x0F
        d0 = done_cnt;
        send_frame(8'hA3, 1'b1, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b1); exp_data = 8'h0F;
        idle(2 * CPB);
        check("b2b_done_count", done_cnt - d0, 32'd2);
        check("b2b_first", {24'd0, (got_q.size() > 0) ? got_q[0] : 8'hxx}, 32'hA3);
        check("b2b_second", {24'd0, (got_q.size() > 1) ? got_q[1] : 8'hxx}, 32'h0F);
        check("b2b_rx_data", {24'd0, u_if.rx_data}, {24'd0, exp_data});
        got_q.delete();

        // False start: 3-cycle low glitch
        d0 = done_cnt; f0 = ferr_cnt;
        u_if.rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(2 * CPB);
        check("glitch_done", done_cnt - d0, 32'd0);
        check("glitch_frame_err", ferr_cnt - f0, 32'd0);
        check("glitch_rx_data", {24'd0, u_if.rx_data}, {24'd0, exp_data});

        // Random frames with random gaps, checked against the byte model
        d0 = done_cnt; p0 = perr_cnt; exp_perr = 0; nrand = 6;
        exp_q.delete();
        for (int k = 0; k < nrand; k++) begin
            rb = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            send_frame(rb, 1'b1, rp);
            exp_q.push_back(rb);
            exp_data = rb;
`ifdef UART_RX_PARITY_EN
            if (!rp) exp_perr++;
`endif
            idle($urandom_range(0, 3));
        end
        idle(2 * CPB);
        check("rand_done_count", done_cnt - d0, nrand);
        for (int k = 0; k < nrand; k++) begin
            check($sformatf("rand_byte%0d", k), {24'd0, (got_q.size() > k) ? got_q[k] : 8'hxx},
                  {24'd0, exp_q[k]});
        end
        check("rand_parity_errs", perr_cnt - p0, exp_perr);
        check("rand_rx_data", {24'd0, u_if.rx_data}, {24'd0, exp_data});
        got_q.delete();

        // Frame error: 0x3C with low stop bit, line then held low
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        u_if.rx = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        check("ferr_count", ferr_cnt - f0, 32'd1);
        check("ferr_no_done", done_cnt - d0, 32'd0);
        check("ferr_rx_data_kept", {24'd0, u_if.rx_data}, {24'd0, exp_data});
        idle(2 * CPB);
        check("ferr_held_low_no_frame", (done_cnt - d0) + (ferr_cnt - f0), 32'd1);

        // Reset for one cycle during data bit 4 of 0x81; transmitter then
        // finishes the data bits and releases the line.
        d0 = done_cnt; f0 = ferr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'($unsigned(8'h81 >> i)));
        u_if.rx = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        check("rst_mid_rx_data", {24'd0, u_if.rx_data}, 32'h00);
        repeat (CPB - 5) @(negedge clk);
        for (int i = 5; i < 8; i++) drive_bit(1'($unsigned(8'h81 >> i)));
        idle(3 * CPB);
        check("rst_mid_no_done", done_cnt - d0, 32'd0);
        check("rst_mid_no_ferr", ferr_cnt - f0, 32'd0);
        check("rst_mid_rx_data_after", {24'd0, u_if.rx_data}, {24'd0, exp_data});
        d0 = done_cnt;
        send_frame(8'h81, 1'b1, 1'b1); exp_data = 8'h81;
        idle(2 * CPB);
        check("rst_clean_done", done_cnt - d0, 32'd1);
        check("rst_clean_rx_data", {24'd0, u_if.rx_data}, {24'd0, exp_data});

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has three ones, so the even parity bit is 1
        d0 = done_cnt; p0 = perr_cnt; pd0 = perr_with_done;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2 * CPB);
        check("par_ok_done", done_cnt - d0, 32'd1);
        check("par_ok_no_perr", perr_cnt - p0, 32'd0);
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(2 * CPB);
        check("par_bad_done", done_cnt - d0, 32'd1);
        check("par_bad_perr", perr_cnt - p0, 32'd1);
        check("par_bad_same_cycle", perr_with_done - pd0, 32'd1);
`else
        check("no_parity_never_perr", perr_cnt, 32'd0);
`endif

        // Global pulse properties
        check("done_ferr_never_together", coincide_cnt, 32'd0);
        check("pulses_single_cycle", wide_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
